// File: rtl/tsq_sched_pkg.sv
// Shared definitions for the time-sensitive queue scheduler:
// FSM state encoding, queue index constants and default timing values.
package tsq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tsq_state_e;

    localparam logic [1:0] Q0_IDX = 2'd0;
    localparam logic [1:0] Q1_IDX = 2'd1;
    localparam logic [1:0] Q2_IDX = 2'd2;
    localparam logic [1:0] Q3_IDX = 2'd3;

    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int GUARD_LEN_DEF   = 24;

    // One-hot read strobe vector for a queue index.
    function automatic logic [3:0] q_onehot(input logic [1:0] idx);
        q_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/tsq_sched_if.sv
// Queue-side and port-side signals of the scheduler, grouped so the
// scheduler sees a single bundle; clk/rst_n stay outside.
interface tsq_sched_if;

    logic [3:0]  in_ts_fifo_empty;
    logic [3:0]  in_ts_gate_open;
    logic [10:0] in_ts_pkt_len;
    logic [15:0] in_ts_gate_remain;
    logic        in_ts_tx_done;

    logic        out_ts_q0_rden;
    logic        out_ts_q1_rden;
    logic        out_ts_q2_rden;
    logic        out_ts_q3_rden;
    logic        out_ts_busy;
    logic        out_ts_timeout;
    logic [1:0]  out_ts_grant_q;

    // Environment side: drives queue status, observes strobes.
    modport master (
        output in_ts_fifo_empty, in_ts_gate_open, in_ts_pkt_len,
               in_ts_gate_remain, in_ts_tx_done,
        input  out_ts_q0_rden, out_ts_q1_rden, out_ts_q2_rden,
               out_ts_q3_rden, out_ts_busy, out_ts_timeout, out_ts_grant_q
    );

    // Scheduler side.
    modport slave (
        input  in_ts_fifo_empty, in_ts_gate_open, in_ts_pkt_len,
               in_ts_gate_remain, in_ts_tx_done,
        output out_ts_q0_rden, out_ts_q1_rden, out_ts_q2_rden,
               out_ts_q3_rden, out_ts_busy, out_ts_timeout, out_ts_grant_q
    );

endinterface

// File: rtl/tsq_prio_enc.sv
// Strict-priority encoder: lowest-numbered eligible queue wins.
module tsq_prio_enc
    import tsq_sched_pkg::*;
(
    input  logic [3:0] elig_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    // Pick q0 over q1 over q2 over q3.
    always_comb begin
        valid_o = |elig_i;
        idx_o   = Q3_IDX;
        if (elig_i[0]) begin
            idx_o = Q0_IDX;
        end else if (elig_i[1]) begin
            idx_o = Q1_IDX;
        end else if (elig_i[2]) begin
            idx_o = Q2_IDX;
        end
    end

endmodule

// File: rtl/tsq_sched.sv
// Time-sensitive queue scheduler: grants one of four queues by strict
// priority, pulses that queue's metadata read, then waits for the port to
// finish the packet (or times out).
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | waiting for an eligible queue; decision taken here
// ST_READ      | registered rden of the latched queue is high (1 cycle)
// ST_WAIT_DONE | waiting for tx_done; counter runs toward the timeout
module tsq_sched
    import tsq_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int GUARD_LEN   = GUARD_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    tsq_sched_if.slave   ts
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    tsq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rden_q, rden_d;
    logic [1:0]       grant_idx_q, grant_idx_d;
    logic             timeout_w;

    logic [3:0]       elig_w;
    logic             q2_fit_w;
    logic             enc_valid_w;
    logic [1:0]       enc_idx_w;

    // Queue eligibility; the queue-2 fit check is widened so that a long
    // packet plus guard can never wrap and look like it fits.
    always_comb begin
        q2_fit_w = ({6'd0, ts.in_ts_pkt_len} + 17'(GUARD_LEN))
                   <= {1'b0, ts.in_ts_gate_remain};
        elig_w   = ~ts.in_ts_fifo_empty & ts.in_ts_gate_open;
        elig_w[2] = elig_w[2] & q2_fit_w;
    end

    tsq_prio_enc u_prio_enc (
        .elig_i  (elig_w),
        .valid_o (enc_valid_w),
        .idx_o   (enc_idx_w)
    );

    // State, counter, strobe and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rden_q      <= '0;
            grant_idx_q <= Q0_IDX;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rden_q      <= rden_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    // Next-state logic; rden is only loaded on the IDLE decision, so it
    // falls back to zero on its own after the single READ cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        rden_d      = '0;
        grant_idx_d = grant_idx_q;
        timeout_w   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid_w) begin
                    state_d     = ST_READ;
                    grant_idx_d = enc_idx_w;
                    rden_d      = q_onehot(enc_idx_w);
                end
            end
            ST_READ: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (ts.in_ts_tx_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_w = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ts.out_ts_q0_rden = rden_q[0];
    assign ts.out_ts_q1_rden = rden_q[1];
    assign ts.out_ts_q2_rden = rden_q[2];
    assign ts.out_ts_q3_rden = rden_q[3];
    assign ts.out_ts_busy    = (state_q == ST_READ) || (state_q == ST_WAIT_DONE);
    assign ts.out_ts_timeout = timeout_w;
    assign ts.out_ts_grant_q = grant_idx_q;

endmodule

// File: tb/tb_tsq_sched.sv
// Self-checking bench for tsq_sched: directed scenarios followed by
// random traffic, all compared against a transaction-level model.
module tb_tsq_sched;
    import tsq_sched_pkg::*;

    localparam int TO = 16;
    localparam int GL = GUARD_LEN_DEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tsq_sched_if ts();

    tsq_sched #(.TIMEOUT_CYC(TO), .GUARD_LEN(GL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ts    (ts)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = idle, 1 = read strobe visible, 2 = waiting.
    int m_phase = 0;
    int m_wait  = 0;
    int m_grant = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] rden_vec();
        return {ts.out_ts_q3_rden, ts.out_ts_q2_rden, ts.out_ts_q1_rden, ts.out_ts_q0_rden};
    endfunction

    function automatic bit is_elig(int q, logic [3:0] e, logic [3:0] g, int len, int rem);
        if (e[q] == 1'b1) return 1'b0;
        if (g[q] == 1'b0) return 1'b0;
        if (q == 2 && (len + GL) > rem) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_wait  = 0;
        m_grant = 0;
    endtask

    task automatic model_step(logic [3:0] e, logic [3:0] g, int len, int rem, logic txd);
        if (m_phase == 0) begin
            for (int q = 0; q < 4; q++) begin
                if (is_elig(q, e, g, len, rem)) begin
                    m_grant = q;
                    m_phase = 1;
                    break;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_wait  = 0;
        end else begin
            if (txd) m_phase = 0;
            else if (m_wait == TO - 1) m_phase = 0;
            else m_wait++;
        end
    endtask

    task automatic check_outputs(logic txd);
        logic [3:0] exp_rd;
        exp_rd = (m_phase == 1) ? (4'b0001 << m_grant) : 4'b0000;
        check_val("rden", rden_vec(), exp_rd);
        check_val("busy", ts.out_ts_busy, m_phase != 0);
        check_val("grant_q", ts.out_ts_grant_q, m_grant);
        check_val("timeout", ts.out_ts_timeout, (m_phase == 2) && (m_wait == TO - 1) && !txd);
        check_val("onehot", $countones(rden_vec()) <= 1, 1);
    endtask

    // One clock: drive at negedge, check just after, advance the model.
    task automatic cycle(logic [3:0] e, logic [3:0] g, int len, int rem, logic txd);
        @(negedge clk);
        ts.in_ts_fifo_empty  = e;
        ts.in_ts_gate_open   = g;
        ts.in_ts_pkt_len     = 11'(len);
        ts.in_ts_gate_remain = 16'(rem);
        ts.in_ts_tx_done     = txd;
        #1;
        check_outputs(txd);
        model_step(e, g, len, rem, txd);
    endtask

    task automatic drain();
        repeat (3) cycle(4'hF, 4'h0, 0, 0, 1'b1);
    endtask

    initial begin
        int hit;
        int left;
        logic [3:0] e;
        int len;
        int rem;

        ts.in_ts_fifo_empty  = 4'hF;
        ts.in_ts_gate_open   = 4'h0;
        ts.in_ts_pkt_len     = '0;
        ts.in_ts_gate_remain = '0;
        ts.in_ts_tx_done     = 1'b0;
        model_reset();
        #1;
        check_val("rst_rden", rden_vec(), 0);
        check_val("rst_busy", ts.out_ts_busy, 0);
        check_val("rst_timeout", ts.out_ts_timeout, 0);
        check_val("rst_grant", ts.out_ts_grant_q, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // q0 granted, q1 only after tx_done
        cycle(4'b1100, 4'hF, 0, 0, 1'b0);
        cycle(4'b1101, 4'hF, 0, 0, 1'b0);
        check_val("r032_q0", ts.out_ts_q0_rden, 1);
        repeat (3) begin
            cycle(4'b1101, 4'hF, 0, 0, 1'b0);
            check_val("r032_q1_early", ts.out_ts_q1_rden, 0);
        end
        cycle(4'b1101, 4'hF, 0, 0, 1'b1);
        cycle(4'b1101, 4'hF, 0, 0, 1'b0);
        check_val("r032_q1_gap", ts.out_ts_q1_rden, 0);
        cycle(4'b1101, 4'hF, 0, 0, 1'b0);
        check_val("r032_q1", ts.out_ts_q1_rden, 1);
        drain();

        // queue-2 fit boundary
        repeat (3) begin
            cycle(4'b1011, 4'b0100, 1000, 1023, 1'b0);
            check_val("r033_nofit", ts.out_ts_q2_rden, 0);
        end
        cycle(4'b1011, 4'b0100, 1000, 1024, 1'b0);
        cycle(4'b1011, 4'b0100, 1000, 1024, 1'b0);
        check_val("r033_fit", ts.out_ts_q2_rden, 1);
        drain();

        // timeout on the 16th wait cycle
        cycle(4'b0111, 4'b1000, 0, 0, 1'b0);
        cycle(4'hF, 4'h0, 0, 0, 1'b0);
        check_val("r034_q3", ts.out_ts_q3_rden, 1);
        hit = 0;
        for (int i = 1; i <= 40 && hit == 0; i++) begin
            cycle(4'hF, 4'h0, 0, 0, 1'b0);
            if (ts.out_ts_timeout) hit = i;
        end
        check_val("r034_at", hit, TO);
        cycle(4'hF, 4'h0, 0, 0, 1'b0);
        check_val("r034_idle", ts.out_ts_busy, 0);

        // tx_done coinciding with the timeout wins
        cycle(4'b0111, 4'b1000, 0, 0, 1'b0);
        cycle(4'hF, 4'h0, 0, 0, 1'b0);
        repeat (TO - 1) cycle(4'hF, 4'h0, 0, 0, 1'b0);
        cycle(4'hF, 4'h0, 0, 0, 1'b1);
        check_val("r035_no_to", ts.out_ts_timeout, 0);
        cycle(4'hF, 4'h0, 0, 0, 1'b0);
        check_val("r035_idle", ts.out_ts_busy, 0);

        // strict priority with q0 draining after three grants
        left = 3;
        for (int r = 0; r < 6; r++) begin
            e = {3'b000, left == 0};
            cycle(e, 4'hF, 0, 2047, 1'b0);
            cycle(e, 4'hF, 0, 2047, 1'b0);
            check_val("r036_order", rden_vec(), (r < 3) ? 4'b0001 : 4'b0010);
            if (ts.out_ts_q0_rden) left--;
            cycle(e, 4'hF, 0, 2047, 1'b1);
        end
        drain();

        // asynchronous reset in the middle of a wait
        cycle(4'b1101, 4'b0010, 0, 0, 1'b0);
        cycle(4'hF, 4'h0, 0, 0, 1'b0);
        repeat (4) cycle(4'hF, 4'h0, 0, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("r037_rden", rden_vec(), 0);
        check_val("r037_busy", ts.out_ts_busy, 0);
        check_val("r037_timeout", ts.out_ts_timeout, 0);
        check_val("r037_grant", ts.out_ts_grant_q, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            cycle(4'hF, 4'hF, 0, 0, 1'b0);
            check_val("r037_no_regrant", ts.out_ts_busy, 0);
        end
        cycle(4'b1101, 4'b0010, 0, 0, 1'b0);
        cycle(4'hF, 4'h0, 0, 0, 1'b0);
        check_val("r037_regrant", ts.out_ts_q1_rden, 1);
        drain();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            len = int'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 1) rem = len + GL - 1 + int'($urandom_range(0, 2));
            else rem = int'($urandom_range(0, 65535));
            if (rem > 65535) rem = 65535;
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), len, rem,
                  $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
